spi_sample_assembler: RTL and testbench

- Sits directly downstream of SPI_slave.
- Takes the received-byte strobe and data and packs consecutive bytes MSB-first into signed samples.
- Buffers the samples in a small first-word-fall-through FIFO and presents them to the FIR datapath over a valid/ready handshake.
- SSEL framing (frame_active) aligns the byte phase; faults are reported through sticky overflow and frame-error flags.

---
 rtl/spi_sample_assembler.sv | 171 +++++++++++++++++
 tb/tb_spi_sample_assembler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sample_assembler.sv
// -----------------------------------------------------------------------------
// spi_sample_assembler
//
// Packs consecutive bytes from SPI_slave (MSB-first) into SAMPLE_W-bit samples.
// The samples are buffered in a small first-word-fall-through FIFO and handed to
// the FIR datapath over a valid/ready handshake. SSEL framing (frame_active)
// re-aligns the byte phase at the start of every frame. Two sticky flags report
// faults:
//   overflow    - a completed sample was dropped because the FIFO was full
//   frame_error - a frame ended while a sample was only partly assembled
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   frame_active  SSEL asserted (already synchronised to clk)
//   byte_valid    one-cycle strobe, byte_data holds a received byte
//   byte_data     received byte
//   sample_data   FIFO head sample (meaningful while sample_valid is high)
//   sample_valid  FIFO not empty
//   sample_ready  consumer accepts the head sample
//   fifo_count    number of stored samples, 0..FIFO_DEPTH
//   overflow      sticky overflow flag
//   frame_error   sticky partial-frame flag
//   clear_flags   one-cycle pulse clearing both sticky flags
// -----------------------------------------------------------------------------
module spi_sample_assembler #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_active,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  output logic [SAMPLE_W-1:0]           sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_error,
  input  logic                          clear_flags
);

  localparam int BYTES = SAMPLE_W / 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic {
    IDLE,
    ASSEMBLE
  } state_t;

  state_t              state;
  logic [IW-1:0]       byte_idx;
  logic [SAMPLE_W-1:0] shift_q;

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic [SAMPLE_W-1:0] next_shift;
  logic                take_byte;
  logic                last_byte;
  logic                push;
  logic                pop;
  logic                full;
  logic                accept;
  logic                drop;
  logic                partial_end;

  // NOTE: every signal driven in always_comb gets a default first so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    next_shift  = '0;
    take_byte   = 1'b0;
    last_byte   = 1'b0;
    partial_end = 1'b0;

    // Shifting left by a whole byte also covers SAMPLE_W == 8, where the old
    // contents fall off entirely.
    next_shift  = (shift_q << 8) | SAMPLE_W'(byte_data);
    take_byte   = (state == ASSEMBLE) && frame_active && byte_valid;
    last_byte   = (byte_idx == IW'(BYTES - 1));
    partial_end = (state == ASSEMBLE) && !frame_active && (byte_idx != '0);
  end

  assign push   = take_byte && last_byte;
  assign pop    = sample_valid && sample_ready;
  assign full   = (count == CW'(FIFO_DEPTH));
  // A full FIFO still accepts the new sample when the head leaves this cycle.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // Byte-phase state machine.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_idx <= '0;
      shift_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Bytes outside a frame are ignored; a new frame starts at byte 0.
          if (frame_active) begin
            state    <= ASSEMBLE;
            byte_idx <= '0;
          end
        end
        ASSEMBLE: begin
          if (!frame_active) begin
            // Any partial sample is abandoned; byte_valid this cycle is ignored.
            state    <= IDLE;
            byte_idx <= '0;
          end else if (byte_valid) begin
            shift_q  <= next_shift;
            byte_idx <= last_byte ? '0 : byte_idx + IW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          byte_idx <= '0;
        end
      endcase
    end
  end

  // FIFO storage.
  // NOTE: the sample memory has no reset; emptiness is tracked by the pointers
  // and count, and sample_data is gated to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= next_shift;
    end
  end

  // FIFO pointers, occupancy and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // A set event in the same cycle as clear_flags wins.
      overflow    <= (overflow && !clear_flags) || drop;
      frame_error <= (frame_error && !clear_flags) || partial_end;
    end
  end

  assign sample_valid = (count != '0);
  assign sample_data  = sample_valid ? mem[rd_ptr] : '0;
  assign fifo_count   = count;

endmodule

// File: tb/tb_spi_sample_assembler.sv
// -----------------------------------------------------------------------------
// tb_spi_sample_assembler
//
// Directed bench for spi_sample_assembler (SAMPLE_W=16, FIFO_DEPTH=4).
// Expected samples are queued in a scoreboard as their final byte is driven
// and popped when the DUT presents them at the FIFO head.
// -----------------------------------------------------------------------------
module tb_spi_sample_assembler;

  localparam int SW = 16;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_active;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic [SW-1:0] sample_data;
  logic          sample_valid;
  logic          sample_ready;
  logic [2:0]    fifo_count;
  logic          overflow;
  logic          frame_error;
  logic          clear_flags;

  int tests_run = 0;
  int tests_failed = 0;

  logic [SW-1:0] exp_q [$];

  spi_sample_assembler #(
    .SAMPLE_W   (SW),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_active (frame_active),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .frame_error  (frame_error),
    .clear_flags  (clear_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  // Sends a whole sample; the scoreboard only expects it when the FIFO has room.
  task automatic send_sample(input logic [SW-1:0] s);
    send_byte(s[15:8]);
    if (exp_q.size() < D) exp_q.push_back(s);
    send_byte(s[7:0]);
  endtask

  task automatic pop_check(input string tag);
    logic [SW-1:0] exp;
    int n;
    n = 0;
    while (sample_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check({tag, " valid"}, 32'(sample_valid), 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check({tag, " data"}, 32'(sample_data), 32'(exp));
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    frame_active = 1'b0;
    byte_valid   = 1'b0;
    byte_data    = 8'h00;
    sample_ready = 1'b0;
    clear_flags  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("rst count", 32'(fifo_count), 32'd0);
    check("rst valid", 32'(sample_valid), 32'd0);
    check("rst data", 32'(sample_data), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst frame_error", 32'(frame_error), 32'd0);

    // 1. Basic assembly with a gap between the bytes.
    frame_active = 1'b1;
    tick();
    send_byte(8'h12);
    repeat (10) tick();
    check("t1 valid before last byte", 32'(sample_valid), 32'd0);
    exp_q.push_back(16'h1234);
    send_byte(8'h34);
    check("t1 valid", 32'(sample_valid), 32'd1);
    check("t1 data", 32'(sample_data), 32'h1234);
    check("t1 count", 32'(fifo_count), 32'd1);
    void'(exp_q.pop_front());
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    check("t1 valid after pop", 32'(sample_valid), 32'd0);
    check("t1 count after pop", 32'(fifo_count), 32'd0);

    // 2. Backpressure and overflow.
    for (int i = 1; i <= 5; i++) begin
      send_sample(SW'(i));
      check($sformatf("t2 count after %0d", i), 32'(fifo_count), (i < D) ? 32'(i) : 32'(D));
      check($sformatf("t2 overflow after %0d", i), 32'(overflow), (i > D) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < D; i++) pop_check($sformatf("t2 drain %0d", i));
    check("t2 count drained", 32'(fifo_count), 32'd0);
    check("t2 overflow sticky", 32'(overflow), 32'd1);
    pulse_clear();
    check("t2 overflow cleared", 32'(overflow), 32'd0);

    // 3. Partial frame, then re-alignment on the next frame.
    exp_q.push_back(16'hABCD);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    frame_active = 1'b0;
    tick();
    check("t3 frame_error", 32'(frame_error), 32'd1);
    check("t3 count", 32'(fifo_count), 32'd1);
    frame_active = 1'b1;
    tick();
    send_sample(16'h1122);
    check("t3 count realigned", 32'(fifo_count), 32'd2);
    pop_check("t3 partial frame sample");
    pop_check("t3 realigned sample");

    // 4. Push and pop in the same cycle while full.
    for (int i = 0; i < D; i++) send_sample(16'hA000 + SW'(i));
    check("t4 full count", 32'(fifo_count), 32'd4);
    send_byte(8'hA0);
    check("t4 head before swap", 32'(sample_data), 32'hA000);
    void'(exp_q.pop_front());
    exp_q.push_back(16'hA004);
    byte_valid   = 1'b1;
    byte_data    = 8'h04;
    sample_ready = 1'b1;
    tick();
    byte_valid   = 1'b0;
    sample_ready = 1'b0;
    check("t4 count held", 32'(fifo_count), 32'd4);
    check("t4 overflow clear", 32'(overflow), 32'd0);
    for (int i = 0; i < D; i++) pop_check($sformatf("t4 drain %0d", i));

    // 5. Reset mid-operation (frame_error still set from the partial frame).
    send_sample(16'hB001);
    send_sample(16'hB002);
    send_byte(8'hC3);
    check("t5 frame_error before rst", 32'(frame_error), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t5 count", 32'(fifo_count), 32'd0);
    check("t5 valid", 32'(sample_valid), 32'd0);
    check("t5 overflow", 32'(overflow), 32'd0);
    check("t5 frame_error", 32'(frame_error), 32'd0);
    tick();
    send_sample(16'h5A5B);
    check("t5 count fresh", 32'(fifo_count), 32'd1);
    pop_check("t5 fresh sample");

    // 6. Gating outside a frame, and set-over-clear priority.
    frame_active = 1'b0;
    tick();
    check("t6 aligned end no error", 32'(frame_error), 32'd0);
    send_byte(8'h77);
    send_byte(8'h88);
    check("t6 gated count", 32'(fifo_count), 32'd0);
    check("t6 gated valid", 32'(sample_valid), 32'd0);
    frame_active = 1'b1;
    tick();
    send_sample(16'h99AA);
    check("t6 count after gate", 32'(fifo_count), 32'd1);
    check("t6 head after gate", 32'(sample_data), 32'h99AA);
    for (int i = 1; i < D; i++) send_sample(16'hC000 + SW'(i));
    check("t6 full", 32'(fifo_count), 32'd4);
    send_byte(8'hDD);
    byte_valid  = 1'b1;
    byte_data   = 8'hEE;
    clear_flags = 1'b1;
    tick();
    byte_valid  = 1'b0;
    clear_flags = 1'b0;
    check("t6 overflow set wins", 32'(overflow), 32'd1);
    check("t6 count after drop", 32'(fifo_count), 32'd4);
    tick();
    check("t6 overflow sticky", 32'(overflow), 32'd1);
    pulse_clear();
    check("t6 overflow cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < D; i++) pop_check($sformatf("t6 drain %0d", i));
    check("t6 empty", 32'(sample_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
